// File: rtl/if_prefetch.sv
// ============================================================================
// if_prefetch : instruction-fetch prefetch queue with jump/branch redirect
// Revision    : 1.0
// ============================================================================
`default_nettype none

`ifndef IFP_EXEC
`define IFP_EXEC 1'b1
`endif

module if_prefetch #(
    parameter int          PC_W     = 8,
    parameter int          IR_W     = 16,
    parameter int          DEPTH    = 2,
    parameter int          RESET_PC = 0,
    parameter logic [4:0]  OP_BZ    = 5'h10,
    parameter logic [4:0]  OP_BNZ   = 5'h11,
    parameter logic [4:0]  OP_BN    = 5'h12,
    parameter logic [4:0]  OP_BNN   = 5'h13,
    parameter logic [4:0]  OP_BC    = 5'h14,
    parameter logic [4:0]  OP_BNC   = 5'h15,
    parameter logic [4:0]  OP_JMPR  = 5'h16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         state,
    output logic [PC_W-1:0]              i_addr,
    input  logic [IR_W-1:0]              i_datain,
    input  logic                         jp_en,
    input  logic [PC_W-1:0]              jp_addr,
    input  logic [IR_W-1:0]              mem_ir,
    input  logic [IR_W-1:0]              reg_C,
    input  logic                         zf,
    input  logic                         nf,
    input  logic                         cf,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [IR_W-1:0]              id_ir,
    output logic [PC_W-1:0]              id_pc,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PC_W-1:0]  pc_q,    pc_d;
    logic [PTR_W-1:0] head_q,  head_d;
    logic [PTR_W-1:0] tail_q,  tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IR_W-1:0]  ir_q   [DEPTH];
    logic [PC_W-1:0]  epc_q  [DEPTH];

    logic             w_exec;
    logic [4:0]       w_op;
    logic             w_br_taken;
    logic             w_redirect;
    logic [PC_W-1:0]  w_target;
    logic             w_push;
    logic             w_pop;
    logic             unused_bits;

    assign w_exec = (state == `IFP_EXEC);
    assign w_op   = mem_ir[IR_W-1 -: 5];

    always_comb begin
        w_br_taken = 1'b0;
        case (w_op)
            OP_BZ:   w_br_taken = zf;
            OP_BNZ:  w_br_taken = ~zf;
            OP_BN:   w_br_taken = nf;
            OP_BNN:  w_br_taken = ~nf;
            OP_BC:   w_br_taken = cf;
            OP_BNC:  w_br_taken = ~cf;
            OP_JMPR: w_br_taken = 1'b1;
            default: w_br_taken = 1'b0;
        endcase
    end

    // An absolute jump outranks a branch resolving in MEM the same cycle.
    assign w_redirect = w_exec & (jp_en | w_br_taken);
    assign w_target   = jp_en ? jp_addr : reg_C[PC_W-1:0];

    assign id_valid = (count_q != '0);
    assign w_pop    = w_exec & ~w_redirect & id_valid & id_ready;
    assign w_push   = w_exec & ~w_redirect & ((count_q != CNT_W'(DEPTH)) | w_pop);

    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_redirect) begin
            pc_d    = w_target;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                pc_d   = pc_q + 1'b1;
                tail_d = tail_q + 1'b1;
            end
            if (w_pop) begin
                head_d = head_q + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q    <= PC_W'(RESET_PC);
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Each entry keeps the fetch address alongside the word for later stages.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ir_q[i]  <= '0;
                epc_q[i] <= '0;
            end
        end else if (w_push) begin
            ir_q[tail_q]  <= i_datain;
            epc_q[tail_q] <= pc_q;
        end
    end

    assign i_addr  = pc_q;
    assign q_count = count_q;
    assign id_ir   = id_valid ? ir_q[head_q]  : '0;
    assign id_pc   = id_valid ? epc_q[head_q] : '0;

    assign unused_bits = ^{reg_C, mem_ir};

endmodule

`default_nettype wire
